// File: rtl/jtcontra_gfx_linebuf.sv
// Double-banked scanline buffer between the 007121 tilemap renderer and the
// colour mixer. The renderer fills one bank through port A while this block
// reads the other bank at pixel rate through port B. Each location is erased
// right after it is read, so the next fill of that bank starts transparent.
// After reset a sweep clears the whole RAM before normal operation starts.
module jtcontra_gfx_linebuf #(
  parameter int AW = 9,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [AW-1:0] hdump,
  input  logic          line,
  input  logic [AW:0]   line_addr,
  input  logic [DW-1:0] line_din,
  input  logic          line_we,
  output logic [DW-1:0] pxl_out,
  output logic          scrwin_out,
  output logic          init_busy
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;

  // Sweep counter has one extra bit; it sets once the last address is cleared.
  localparam logic [AW+1:0] CNT_ONE = {{(AW+1){1'b0}}, 1'b1};

  logic [DW-1:0] mem [0:(2<<AW)-1];
  logic [DW-1:0] rd_data_q;

  logic [1:0]    state_q,   state_d;
  logic [AW+1:0] cnt_q,     cnt_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0] pxl_out_q, pxl_out_d;
  logic          scrwin_q,  scrwin_d;
  logic          busy_q,    busy_d;

  logic          we_a;
  logic          we_b;
  logic          re_b;
  logic [AW:0]   addr_b;

  // Next-state logic: clear sweep, pixel sample, then read-and-erase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    pxl_out_d = pxl_out_q;
    scrwin_d  = scrwin_q;
    busy_d    = busy_q;
    we_a      = line_we && (state_q != ST_INIT);
    we_b      = 1'b0;
    re_b      = 1'b0;
    addr_b    = rd_addr_q;
    case (state_q)
      ST_INIT: begin
        pxl_out_d = '0;
        scrwin_d  = 1'b0;
        if (cnt_q[AW+1]) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          we_b   = 1'b1;
          addr_b = cnt_q[AW:0];
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (pxl_cen) begin
          if (LHBL && LVBL) begin
            rd_addr_d = {~line, hdump};
            addr_b    = rd_addr_d;
            re_b      = 1'b1;
            state_d   = ST_READ;
          end else begin
            pxl_out_d = '0;
            scrwin_d  = 1'b0;
          end
        end
      end
      ST_READ: begin
        pxl_out_d = rd_data_q;
        scrwin_d  = rd_data_q[DW-1];
        addr_b    = rd_addr_q;
        // A renderer write to the same word in this cycle takes precedence
        we_b      = !(we_a && (line_addr == rd_addr_q));
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Control registers with synchronous reset restarting the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      pxl_out_q <= '0;
      scrwin_q  <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      pxl_out_q <= pxl_out_d;
      scrwin_q  <= scrwin_d;
      busy_q    <= busy_d;
    end
  end

  // Line RAM: synchronous read-before-write, port A ordered last so it wins.
  always_ff @(posedge clk) begin
    if (re_b) rd_data_q <= mem[addr_b];
    if (we_b) mem[addr_b] <= '0;
    if (we_a) mem[line_addr] <= line_din;
  end

  assign pxl_out    = pxl_out_q;
  assign scrwin_out = scrwin_q;
  assign init_busy  = busy_q;

endmodule

// File: tb/tb_jtcontra_gfx_linebuf.sv
// Directed testbench for the double-banked scanline buffer.
module tb_jtcontra_gfx_linebuf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic       LVBL = 1'b1;
  logic [8:0] hdump = '0;
  logic       line = 1'b0;
  logic [9:0] line_addr = '0;
  logic [8:0] line_din = '0;
  logic       line_we = 1'b0;
  logic [8:0] pxl_out;
  logic       scrwin_out;
  logic       init_busy;

  int n_cmp = 0;
  int n_bad = 0;

  jtcontra_gfx_linebuf #(.AW(9), .DW(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .pxl_cen    (pxl_cen),
    .LHBL       (LHBL),
    .LVBL       (LVBL),
    .hdump      (hdump),
    .line       (line),
    .line_addr  (line_addr),
    .line_din   (line_din),
    .line_we    (line_we),
    .pxl_out    (pxl_out),
    .scrwin_out (scrwin_out),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  // Renderer write of one word through port A.
  task automatic write_word(input logic [9:0] a, input logic [8:0] d);
    @(negedge clk);
    line_we   = 1'b1;
    line_addr = a;
    line_din  = d;
    @(posedge clk);
    #1 line_we = 1'b0;
  endtask

  // One pixel slot: sample edge, then the edge where pxl_out updates.
  task automatic read_pixel(input logic [8:0] h, input logic lh, input logic lv,
                            output logic [8:0] px, output logic sw);
    @(negedge clk);
    pxl_cen = 1'b1;
    hdump   = h;
    LHBL    = lh;
    LVBL    = lv;
    @(posedge clk);
    #1 pxl_cen = 1'b0;
    @(posedge clk);
    #1;
    px   = pxl_out;
    sw   = scrwin_out;
    LHBL = 1'b1;
    LVBL = 1'b1;
  endtask

  // Counts edges after the reset edge until init_busy drops (bounded).
  // Injects ignored renderer writes and a pixel sample along the way.
  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (!init_busy) break;
      if (pxl_out !== 9'h000) begin
        n_bad++;
        $display("[TB] FAIL sweep_pxl_zero edge %0d: got %h, want 000", i, pxl_out);
      end
      if (i == 5)   begin pxl_cen = 1'b1; hdump = 9'd40; line = 1'b1; end
      if (i == 6)   pxl_cen = 1'b0;
      if (i == 600) begin line_we = 1'b1; line_addr = 10'h003; line_din = 9'h1FF; end
      if (i == 601) begin line_addr = 10'h203; line_din = 9'h1FF; end
      if (i == 602) line_we = 1'b0;
    end
  endtask

  // Reads a whole bank and returns the number of non-zero words.
  task automatic scan_bank(input logic bank, output int nz);
    logic [8:0] px;
    logic       sw;
    nz   = 0;
    line = ~bank;
    for (int h = 0; h < 512; h++) begin
      read_pixel(h[8:0], 1'b1, 1'b1, px, sw);
      if (px !== 9'h000) nz++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (pxl_out !== 9'h000 || scrwin_out !== 1'b0 || init_busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_state: got pxl=%h scr=%b busy=%b, want 000 0 1",
               pxl_out, scrwin_out, init_busy);
    end
    rst = 1'b0;
    wait_sweep(n);
    n_cmp++;
    if (n != 1025) begin
      n_bad++;
      $display("[TB] FAIL reset_sweep_len: got %0d edges, want 1025", n);
    end
  endtask

  task automatic test_reset_sweep();
    int n;
    int nz;
    for (int a = 0; a < 1024; a++) write_word(a[9:0], 9'h1FF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_sweep(n);
    n_cmp++;
    if (n != 1025) begin
      n_bad++;
      $display("[TB] FAIL preload_sweep_len: got %0d edges, want 1025", n);
    end
    scan_bank(1'b0, nz);
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("[TB] FAIL sweep_bank0_clear: got %0d nonzero words, want 0", nz);
    end
    scan_bank(1'b1, nz);
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("[TB] FAIL sweep_bank1_clear: got %0d nonzero words, want 0", nz);
    end
  endtask

  task automatic test_basic();
    logic [8:0] px;
    logic       sw;
    line = 1'b0;
    write_word(10'h005, 9'h15A);
    line = 1'b1;
    read_pixel(9'd5, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h15A || sw !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL basic_read: got %h/%b, want 15a/1", px, sw);
    end
    read_pixel(9'd5, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h000 || sw !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_erased: got %h/%b, want 000/0", px, sw);
    end
  endtask

  task automatic test_blanking();
    logic [8:0] px;
    logic       sw;
    line = 1'b0;
    write_word(10'h007, 9'h0C3);
    write_word(10'h009, 9'h1F0);
    line = 1'b1;
    read_pixel(9'd9, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h1F0) begin
      n_bad++;
      $display("[TB] FAIL blank_pre: got %h, want 1f0", px);
    end
    read_pixel(9'd7, 1'b0, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h000 || sw !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL hblank_zero: got %h/%b, want 000/0", px, sw);
    end
    write_word(10'h009, 9'h1F0);
    read_pixel(9'd9, 1'b1, 1'b1, px, sw);
    read_pixel(9'd7, 1'b1, 1'b0, px, sw);
    n_cmp++;
    if (px !== 9'h000) begin
      n_bad++;
      $display("[TB] FAIL vblank_zero: got %h, want 000", px);
    end
    read_pixel(9'd7, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h0C3 || sw !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL blank_kept: got %h/%b, want 0c3/0", px, sw);
    end
  endtask

  task automatic test_collision();
    logic [8:0] px;
    logic       sw;
    // Renderer write to the word being erased in the same cycle
    line = 1'b0;
    write_word(10'h00A, 9'h120);
    line = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b1;
    hdump   = 9'd10;
    @(posedge clk);
    #1;
    pxl_cen   = 1'b0;
    line_we   = 1'b1;
    line_addr = 10'h00A;
    line_din  = 9'h0AB;
    @(posedge clk);
    #1;
    line_we = 1'b0;
    n_cmp++;
    if (pxl_out !== 9'h120) begin
      n_bad++;
      $display("[TB] FAIL collide_read: got %h, want 120", pxl_out);
    end
    read_pixel(9'd10, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h0AB) begin
      n_bad++;
      $display("[TB] FAIL collide_portA_wins: got %h, want 0ab", px);
    end
    // Renderer write to the word being read in the sample cycle
    line = 1'b0;
    write_word(10'h00C, 9'h055);
    line = 1'b1;
    @(negedge clk);
    pxl_cen   = 1'b1;
    hdump     = 9'd12;
    line_we   = 1'b1;
    line_addr = 10'h00C;
    line_din  = 9'h066;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
    line_we = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (pxl_out !== 9'h055) begin
      n_bad++;
      $display("[TB] FAIL read_before_write: got %h, want 055", pxl_out);
    end
    read_pixel(9'd12, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h000) begin
      n_bad++;
      $display("[TB] FAIL rbw_erased: got %h, want 000", px);
    end
  endtask

  task automatic test_bank_latch();
    logic [8:0] px;
    logic       sw;
    write_word(10'h014, 9'h111);
    write_word(10'h214, 9'h122);
    line = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b1;
    hdump   = 9'd20;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
    line    = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (pxl_out !== 9'h111 || scrwin_out !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL bank_latch_read: got %h/%b, want 111/1", pxl_out, scrwin_out);
    end
    read_pixel(9'd20, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h122) begin
      n_bad++;
      $display("[TB] FAIL bank_other_kept: got %h, want 122", px);
    end
    line = 1'b1;
    read_pixel(9'd20, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h000) begin
      n_bad++;
      $display("[TB] FAIL bank_latched_erased: got %h, want 000", px);
    end
  endtask

  task automatic test_midop_reset();
    int         n;
    logic [8:0] px;
    logic       sw;
    line = 1'b0;
    write_word(10'h01E, 9'h1AA);
    write_word(10'h028, 9'h1AA);
    line = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b1;
    hdump   = 9'd30;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (pxl_out !== 9'h000 || init_busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL midop_reset: got pxl=%h busy=%b, want 000 1", pxl_out, init_busy);
    end
    wait_sweep(n);
    n_cmp++;
    if (n != 1025) begin
      n_bad++;
      $display("[TB] FAIL midop_sweep_len: got %0d edges, want 1025", n);
    end
    line = 1'b1;
    read_pixel(9'd40, 1'b1, 1'b1, px, sw);
    n_cmp++;
    if (px !== 9'h000) begin
      n_bad++;
      $display("[TB] FAIL midop_swept: got %h, want 000", px);
    end
  endtask

  task automatic test_streaming();
    logic [8:0] px;
    logic [8:0] exp;
    logic       sw;
    int         nz;
    line = 1'b0;
    for (int i = 0; i < 320; i++) begin
      exp = 9'((i * 7 + 3) & 9'h1FF);
      write_word(i[9:0], exp);
    end
    line = 1'b1;
    for (int i = 0; i < 320; i++) begin
      exp = 9'((i * 7 + 3) & 9'h1FF);
      read_pixel(i[8:0], 1'b1, 1'b1, px, sw);
      n_cmp++;
      if (px !== exp || sw !== exp[8]) begin
        n_bad++;
        $display("[TB] FAIL stream_px%0d: got %h/%b, want %h/%b", i, px, sw, exp, exp[8]);
      end
    end
    scan_bank(1'b0, nz);
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("[TB] FAIL stream_bank_erased: got %0d nonzero words, want 0", nz);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_reset_sweep();
    test_basic();
    test_blanking();
    test_collision();
    test_bank_latch();
    test_midop_reset();
    test_streaming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtcontra_gfx_linebuf.md
Name: jtcontra_gfx_linebuf

Overview:
- Double-banked scanline buffer directly downstream of the 007121 tilemap renderer.
- The renderer fills one bank with {scrwin, pal[3:0], pix[3:0]} words during HBLANK and the early line. Meanwhile this block reads the other bank out at pixel rate and erases each location after reading, so the next fill starts transparent.
- The output feeds the colour mixer / priority stage.

Parameters:
- AW, 9, pixel address width per bank (512 entries per bank).
- DW, 9, data width: {scrwin, pal[3:0], pix[3:0]}.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pxl_cen  in  1  pixel clock enable; consecutive pulses are at least 2 clk apart.
- LHBL  in  1  horizontal blank, active low.
- LVBL  in  1  vertical blank, active low.
- hdump  in  AW  current output pixel column.
- line  in  1  bank currently being written by the renderer; read bank = ~line.
- line_addr  in  AW+1  renderer write address {bank, column}.
- line_din  in  DW  renderer write data.
- line_we  in  1  renderer write strobe.
- pxl_out  out  DW  registered pixel word {scrwin, pal, pix}.
- scrwin_out  out  1  copy of pxl_out[8], for the priority stage.
- init_busy  out  1  high while the power-up clear sweep runs.

Behaviour:
- Storage: one (2<<AW) x DW RAM with synchronous read.
  - Port A: renderer writes only.
  - Port B: read then clear.
- Reset:
  - pxl_out=0, scrwin_out=0, init_busy=1.
  - FSM enters INIT with clear counter=0.
  - RAM contents are not reset directly; INIT clears them.
- INIT state:
  - Each clk, write 0 to port-B address = counter, then counter+1.
  - After address 1023 is written, the next cycle sets init_busy=0 and enters IDLE. INIT therefore lasts exactly 1024 clk, and init_busy falls on clk 1025 after rst deasserts.
  - line_we is ignored during INIT: no write reaches the RAM.
  - pxl_out holds 0.
  - rst asserted mid-sweep restarts the sweep at address 0.
- IDLE:
  - If pxl_cen && LHBL && LVBL: latch rd_addr={~line, hdump}, issue a port-B read, go to READ.
  - If pxl_cen && !(LHBL && LVBL): set pxl_out=0, no RAM access, stay in IDLE.
- READ (1 clk after the pxl_cen sample):
  - RAM data is valid: pxl_out <= q, scrwin_out <= q[8].
  - Issue port-B write of 0 at rd_addr, go to IDLE.
  - Total latency: pxl_out updates 2 clk after the sampling pxl_cen edge.
- Bank selection:
  - ~line is evaluated at the pxl_cen sample only.
  - A toggle of line between sample and clear does not move the clear; it uses the latched rd_addr.
- Collision: a port-A write and a port-B clear to the same address in the same clk → port-A data wins and the clear is dropped.
- Port-B read and port-A write to the same address in the same clk → the read returns the old data (read-before-write).
- Arithmetic: no arithmetic on hdump; rd_addr is a plain concatenation with no wrap logic needed.
- line_we with line_addr[AW] == read bank is legal; no check is done and the write is performed.

Test Plan:
- Reset sweep: pulse rst 1 clk, preload RAM with 0x1FF → init_busy high for 1024 clk; every address reads 0 afterwards; line_we pulses during the sweep leave no trace.
- Basic fill/read:
  - Stimulus: line=0, write 0x15A at line_addr 0x005; toggle line to 1; pxl_cen with hdump=5, LHBL=LVBL=1.
  - Required: pxl_out=0x15A and scrwin_out=1 two clk later. A re-read of 0x005 on the next line cycle returns 0.
- Blanking: LHBL=0, pxl_cen with hdump=5 over valid data → pxl_out=0 and the location is not cleared (a later read with LHBL=1 returns the data).
- Collision: force a port-A write of 0x0AB to rd_addr in the same clk as the clear → the location holds 0x0AB afterwards.
- Mid-operation reset: assert rst during READ → pxl_out=0 next clk, init_busy=1, sweep restarts at address 0, full 1024 clk sweep before the first read.
- Streaming: 320 consecutive pxl_cen every 2 clk across hdump 0..319 with ramp data → pxl_out sequence matches the ramp, and the whole read bank is 0 afterwards.
